seg_display_scan: RTL and testbench

Parametrised, time-multiplexed seven-segment driver for the calculator display path. It accepts a signed binary value on a load strobe and converts it to BCD with a sequential double-dabble engine. It then scans the digits onto a shared active-low cathode bus with one-hot active-low anodes. It adds leading-zero blanking, a minus sign, overflow indication and an optional blinking edit digit. It sits between `select_btn_action` (value source) and the board pins, replacing the static per-digit cathode bus.

---
 rtl/seg_display_scan.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_seg_display_scan.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_scan
// Purpose  : Time-multiplexed seven-segment driver. A signed binary value is
//            captured on a load strobe and converted to BCD by a sequential
//            double-dabble engine; the digits are then scanned onto a shared
//            active-low cathode bus with one-hot active-low anodes. Adds
//            leading-zero blanking, a minus sign, overflow indication and an
//            optional blinking edit digit.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_DIGITS  : number of physical digits (>= 2)
//   WIDTH       : width of the signed input value
//   REFRESH_DIV : clk cycles each digit stays enabled (>= 2)
//   BLINK_DIV   : clk cycles per blink half-period (>= 2)
// Ports
//   clk        in  : single clock
//   rst        in  : synchronous, active-high reset
//   value      in  : signed two's-complement value to show
//   load       in  : one-cycle strobe, captures value
//   edit_en    in  : enable blinking of edit_digit
//   edit_digit in  : digit index to blink (0 = rightmost)
//   anode      out : one-hot, active-low digit enable (registered)
//   cathode    out : active-low segments {dp,g,f,e,d,c,b,a} (registered)
//   busy       out : conversion in progress
//   overflow   out : last completed value does not fit
// Configuration
//   SEG_DISPLAY_SCAN_BLINK_EN : when defined, builds the blink counter and
//                               the edit-digit blanking; otherwise edit_en
//                               and edit_digit are ignored.
// ============================================================================
module seg_display_scan #(
    parameter int NUM_DIGITS  = 8,
    parameter int WIDTH       = 32,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              value,
    input  logic                          load,
    input  logic                          edit_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] edit_digit,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic [7:0]                    cathode,
    output logic                          busy,
    output logic                          overflow
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int REF_W = $clog2(REFRESH_DIV);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ABS   = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    // ------------------------------------------------------------------------
    // Segment encoder for one BCD nibble (active low, dp off)
    // ------------------------------------------------------------------------
    function automatic logic [7:0] f_encode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------------
    // Converter state
    // ------------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] value_q;
    logic             neg_q;
    logic [WIDTH-1:0] mag_q;
    logic [BCD_W-1:0] bcd_q;
    logic             carry_q;
    logic [CNT_W-1:0] bit_cnt_q;

    // Single-entry pending slot for loads that arrive while converting
    logic             pend_valid_q;
    logic [WIDTH-1:0] pend_value_q;

    // Committed display content
    logic [BCD_W-1:0] disp_bcd_q;
    logic             disp_neg_q;
    logic             disp_ovf_q;

    // Scan and output registers
    logic [REF_W-1:0]      ref_cnt_q;
    logic [IDX_W-1:0]      scan_idx_q;
    logic [NUM_DIGITS-1:0] anode_q;
    logic [7:0]            cathode_q;

    // ------------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------------
    // Magnitude is formed one bit wider than the input so the most-negative
    // value negates exactly; its top bit can only be set if the magnitude
    // would not fit the shift window, so it is folded into the sticky carry.
    logic [WIDTH:0]   w_mag_full;
    logic [BCD_W-1:0] w_bcd_adj;
    logic [BCD_W-1:0] w_bcd_shift;
    logic             w_carry_out;
    logic             w_commit_carry;
    logic             w_top_nz;
    logic             w_commit_ovf;
    logic             w_last;

    assign w_mag_full = value_q[WIDTH-1] ? ({1'b0, ~value_q} + (WIDTH+1)'(1))
                                         : {1'b0, value_q};

    // Add-3 correction on every nibble that is 5 or more before shifting
    always_comb begin
        w_bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_bcd_shift    = {w_bcd_adj[BCD_W-2:0], mag_q[WIDTH-1]};
    assign w_carry_out    = w_bcd_adj[BCD_W-1];
    assign w_commit_carry = carry_q | w_carry_out;
    assign w_top_nz       = |w_bcd_shift[BCD_W-1 -: 4];
    // A negative result needs the top position free for the '-' sign
    assign w_commit_ovf   = w_commit_carry | (neg_q & w_top_nz);
    assign w_last         = (bit_cnt_q == CNT_W'(WIDTH - 1));

    // ------------------------------------------------------------------------
    // Converter FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (load || pend_valid_q) state_d = ST_ABS;
            ST_ABS:   state_d = ST_SHIFT;
            ST_SHIFT: if (w_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            value_q      <= '0;
            neg_q        <= 1'b0;
            mag_q        <= '0;
            bcd_q        <= '0;
            carry_q      <= 1'b0;
            bit_cnt_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_value_q <= '0;
            disp_bcd_q   <= '0;
            disp_neg_q   <= 1'b0;
            disp_ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    // A fresh strobe supersedes anything left pending
                    if (load) begin
                        value_q      <= value;
                        pend_valid_q <= 1'b0;
                    end else if (pend_valid_q) begin
                        value_q      <= pend_value_q;
                        pend_valid_q <= 1'b0;
                    end
                end
                ST_ABS: begin
                    neg_q     <= value_q[WIDTH-1];
                    mag_q     <= w_mag_full[WIDTH-1:0];
                    carry_q   <= w_mag_full[WIDTH];
                    bcd_q     <= '0;
                    bit_cnt_q <= '0;
                end
                ST_SHIFT: begin
                    bcd_q     <= w_bcd_shift;
                    mag_q     <= {mag_q[WIDTH-2:0], 1'b0};
                    carry_q   <= w_commit_carry;
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    // Atomic commit of the finished conversion
                    if (w_last) begin
                        disp_bcd_q <= w_bcd_shift;
                        disp_neg_q <= neg_q;
                        disp_ovf_q <= w_commit_ovf;
                    end
                end
                default: ;
            endcase
            // Loads during a conversion (including its final cycle) park in
            // the pending slot; the last one wins.
            if (load && (state_q != ST_IDLE)) begin
                pend_value_q <= value;
                pend_valid_q <= 1'b1;
            end
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign overflow = disp_ovf_q;

    // ------------------------------------------------------------------------
    // Optional blink phase
    // ------------------------------------------------------------------------
    logic w_blank_edit;

`ifdef SEG_DISPLAY_SCAN_BLINK_EN
    localparam int BLK_W = $clog2(BLINK_DIV);

    logic [BLK_W-1:0] blink_cnt_q;
    logic             blink_off_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            blink_off_q <= ~blink_off_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BLK_W'(1);
        end
    end

    // Out-of-range indices never match a physical digit
    assign w_blank_edit = blink_off_q & edit_en
                        & ({{(32-IDX_W){1'b0}}, edit_digit} < $unsigned(NUM_DIGITS))
                        & (edit_digit == scan_idx_q);
`else
    logic w_unused_blink;

    assign w_unused_blink = ^{edit_en, edit_digit, 32'(BLINK_DIV)};
    assign w_blank_edit   = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Digit selection: blanking, sign and overflow
    // ------------------------------------------------------------------------
    logic [IDX_W-1:0] w_msd;
    logic [3:0]       w_nib;
    logic             w_minus_here;
    logic [7:0]       w_seg;

    // Most-significant non-zero digit; digit 0 always counts so 0 shows "0"
    always_comb begin
        w_msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (disp_bcd_q[4*i +: 4] != 4'd0) begin
                w_msd = IDX_W'(i);
            end
        end
    end

    assign w_nib        = disp_bcd_q[{scan_idx_q, 2'b00} +: 4];
    // Compared one bit wider so msd+1 cannot wrap onto digit 0
    assign w_minus_here = ({1'b0, scan_idx_q} == ({1'b0, w_msd} + (IDX_W+1)'(1)));

    always_comb begin
        w_seg = SEG_BLANK;
        if (disp_ovf_q) begin
            w_seg = SEG_MINUS;
        end else if (scan_idx_q <= w_msd) begin
            w_seg = f_encode(w_nib);
        end else if (disp_neg_q && w_minus_here) begin
            w_seg = SEG_MINUS;
        end
        if (w_blank_edit) begin
            w_seg = SEG_BLANK;
        end
    end

    // ------------------------------------------------------------------------
    // Scan counter and registered outputs
    // ------------------------------------------------------------------------
    // Both outputs are registered from the same scan index so anode and
    // cathode always switch on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt_q  <= '0;
            scan_idx_q <= '0;
            anode_q    <= '1;
            cathode_q  <= SEG_BLANK;
        end else begin
            if (ref_cnt_q == REF_W'(REFRESH_DIV - 1)) begin
                ref_cnt_q <= '0;
                if (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                    scan_idx_q <= '0;
                end else begin
                    scan_idx_q <= scan_idx_q + IDX_W'(1);
                end
            end else begin
                ref_cnt_q <= ref_cnt_q + REF_W'(1);
            end
            anode_q   <= ~(NUM_DIGITS'(1) << scan_idx_q);
            cathode_q <= w_seg;
        end
    end

    assign anode   = anode_q;
    assign cathode = cathode_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_scan
// Purpose  : Self-checking bench for seg_display_scan (4 digits, 16-bit
//            value, refresh 4, blink 16). Expected digit patterns come from
//            a decimal reference model and are queued at load time, then
//            popped when the converter reports completion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_scan;

    localparam int ND = 4;
    localparam int W  = 16;
    localparam int RD = 4;
    localparam int BD = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  value = '0;
    logic          load = 1'b0;
    logic          edit_en = 1'b0;
    logic [1:0]    edit_digit = '0;
    logic [ND-1:0] anode;
    logic [7:0]    cathode;
    logic          busy;
    logic          overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;   // clock edges since reset release

    logic [32:0] sb_q[$];                // {ovf, seg3, seg2, seg1, seg0}
    logic [31:0] shown = 32'hFFFF_FFC0;  // digit patterns currently committed

    seg_display_scan #(
        .NUM_DIGITS (ND),
        .WIDTH      (W),
        .REFRESH_DIV(RD),
        .BLINK_DIV  (BD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .load      (load),
        .edit_en   (edit_en),
        .edit_digit(edit_digit),
        .anode     (anode),
        .cathode   (cathode),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [32:0] golden(input int v);
        int          m;
        int          d[ND];
        int          msd;
        bit          neg;
        bit          ovf;
        logic [31:0] segs;
        neg = (v < 0);
        m   = neg ? -v : v;
        for (int i = 0; i < ND; i++) d[i] = (m / (10 ** i)) % 10;
        ovf = ((m / (10 ** ND)) != 0) || (neg && d[ND-1] != 0);
        msd = 0;
        for (int i = 0; i < ND; i++) if (d[i] != 0) msd = i;
        for (int i = 0; i < ND; i++) begin
            if (ovf)                     segs[i*8 +: 8] = 8'hBF;
            else if (i <= msd)           segs[i*8 +: 8] = seg_of(d[i]);
            else if (neg && i == msd+1)  segs[i*8 +: 8] = 8'hBF;
            else                         segs[i*8 +: 8] = 8'hFF;
        end
        return {ovf, segs};
    endfunction

    // Expected outputs registered at clock edge k (observed after that edge)
    function automatic logic [ND-1:0] exp_anode(input int k);
        logic [ND-1:0] one = 1;
        int idx = ((k - 1) / RD) % ND;
        return ~(one << idx);
    endfunction

    function automatic logic [7:0] exp_cath(input int k);
        int idx = ((k - 1) / RD) % ND;
        logic [7:0] c = shown[idx*8 +: 8];
`ifdef SEG_DISPLAY_SCAN_BLINK_EN
        if (edit_en && int'(edit_digit) == idx && (((k - 1) / BD) % 2) == 1) c = 8'hFF;
`endif
        return c;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Called at a falling edge; returns at the falling edge after the strobe.
    // A load that lands while one entry is already pending replaces it.
    task automatic do_load(input int v);
        value = v[W-1:0];
        load  = 1'b1;
        if (sb_q.size() >= 2) sb_q[sb_q.size()-1] = golden(v);
        else                  sb_q.push_back(golden(v));
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle(output bit to);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        to = (busy !== 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (anode !== 4'b1111) begin bad++; $display("FAIL reset_anode: got %b want 1111", anode); end
        total++;
        if (cathode !== 8'hFF) begin bad++; $display("FAIL reset_cathode: got %h want ff", cathode); end
        total++;
        if (busy !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL reset_flags: busy=%b overflow=%b want 0 0", busy, overflow);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (anode !== 4'b1110 || cathode !== 8'hC0) begin
            bad++; $display("FAIL reset_first: anode=%b cathode=%h want 1110 c0", anode, cathode);
        end
    endtask

    task automatic test_positive();
        int          n = 0;
        bit          to;
        logic [32:0] exp;
        do_load(1234);
        while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
        total++;
        if (n != W + 1) begin bad++; $display("FAIL pos_busy_len: got %0d want %0d", n, W + 1); end
        wait_idle(to);
        exp = sb_q.pop_front();
        total++;
        if (to || overflow !== exp[32]) begin
            bad++; $display("FAIL pos_ovf: got %b want %b timeout=%0d", overflow, exp[32], to);
        end
        shown = exp[31:0];
        @(negedge clk);
        for (int i = 0; i < ND * RD; i++) begin
            total++;
            if (anode !== exp_anode(cyc) || cathode !== exp_cath(cyc)) begin
                bad++; $display("FAIL pos_scan cyc=%0d: anode=%b cathode=%h want %b %h",
                                cyc, anode, cathode, exp_anode(cyc), exp_cath(cyc));
            end
            @(negedge clk);
        end
    endtask

    // Loads each value, waits for commit, then checks overflow and a full scan
    task automatic test_values(input string name, input int v0, input int v1, input int v2, input int cnt);
        int          vals[3];
        bit          to;
        logic [32:0] exp;
        vals[0] = v0; vals[1] = v1; vals[2] = v2;
        for (int k = 0; k < cnt; k++) begin
            do_load(vals[k]);
            wait_idle(to);
            exp = sb_q.pop_front();
            total++;
            if (to || overflow !== exp[32]) begin
                bad++; $display("FAIL %s_ovf value=%0d: got %b want %b timeout=%0d",
                                name, vals[k], overflow, exp[32], to);
            end
            shown = exp[31:0];
            @(negedge clk);
            for (int i = 0; i < ND * RD; i++) begin
                total++;
                if (anode !== exp_anode(cyc) || cathode !== exp_cath(cyc)) begin
                    bad++; $display("FAIL %s_scan value=%0d cyc=%0d: anode=%b cathode=%h want %b %h",
                                    name, vals[k], cyc, anode, cathode, exp_anode(cyc), exp_cath(cyc));
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_negative_zero();
        test_values("negzero", -42, 0, 0, 2);
    endtask

    task automatic test_overflow();
        test_values("ovf", 12345, -1000, -999, 3);
    endtask

    task automatic test_back_to_back();
        bit          to;
        int          c_first;
        logic [32:0] exp;
        do_load(7);
        repeat (2) @(negedge clk);
        do_load(5);
        @(negedge clk);
        do_load(9);
        wait_idle(to);
        c_first = cyc;
        exp = sb_q.pop_front();
        total++;
        if (to || overflow !== exp[32]) begin
            bad++; $display("FAIL b2b_first_ovf: got %b want %b timeout=%0d", overflow, exp[32], to);
        end
        shown = exp[31:0];
        @(negedge clk);
        for (int i = 0; i < ND * RD; i++) begin
            total++;
            if (anode !== exp_anode(cyc) || cathode !== exp_cath(cyc)) begin
                bad++; $display("FAIL b2b_first_scan cyc=%0d: anode=%b cathode=%h want %b %h",
                                cyc, anode, cathode, exp_anode(cyc), exp_cath(cyc));
            end
            @(negedge clk);
        end
        wait_idle(to);
        total++;
        if (to || (cyc - c_first) != W + 2) begin
            bad++; $display("FAIL b2b_gap: got %0d cycles want %0d timeout=%0d", cyc - c_first, W + 2, to);
        end
        exp = sb_q.pop_front();
        shown = exp[31:0];
        @(negedge clk);
        for (int i = 0; i < ND * RD; i++) begin
            total++;
            if (anode !== exp_anode(cyc) || cathode !== exp_cath(cyc)) begin
                bad++; $display("FAIL b2b_second_scan cyc=%0d: anode=%b cathode=%h want %b %h",
                                cyc, anode, cathode, exp_anode(cyc), exp_cath(cyc));
            end
            @(negedge clk);
        end
        total++;
        if (sb_q.size() != 0) begin bad++; $display("FAIL b2b_queue: got %0d entries left want 0", sb_q.size()); end
    endtask

    task automatic test_blink();
        bit          to;
        logic [32:0] exp;
        do_load(1234);
        wait_idle(to);
        exp = sb_q.pop_front();
        total++;
        if (to || overflow !== exp[32]) begin
            bad++; $display("FAIL blink_ovf: got %b want %b timeout=%0d", overflow, exp[32], to);
        end
        shown = exp[31:0];
        @(negedge clk);
        edit_en    = 1'b1;
        edit_digit = 2'd1;
        @(negedge clk);
        for (int i = 0; i < 4 * ND * RD; i++) begin
            total++;
            if (anode !== exp_anode(cyc) || cathode !== exp_cath(cyc)) begin
                bad++; $display("FAIL blink_scan cyc=%0d: anode=%b cathode=%h want %b %h",
                                cyc, anode, cathode, exp_anode(cyc), exp_cath(cyc));
            end
            @(negedge clk);
        end
        edit_en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2 * ND * RD; i++) begin
            total++;
            if (anode !== exp_anode(cyc) || cathode !== exp_cath(cyc)) begin
                bad++; $display("FAIL noblink_scan cyc=%0d: anode=%b cathode=%h want %b %h",
                                cyc, anode, cathode, exp_anode(cyc), exp_cath(cyc));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int n_busy = 0;
        do_load(-42);
        repeat (2) @(negedge clk);
        do_load(77);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (anode !== 4'b1111 || cathode !== 8'hFF || busy !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL midrst_values: anode=%b cathode=%h busy=%b ovf=%b want 1111 ff 0 0",
                            anode, cathode, busy, overflow);
        end
        rst = 1'b0;
        sb_q.delete();
        shown = 32'hFFFF_FFC0;
        @(negedge clk);
        total++;
        if (anode !== 4'b1110 || cathode !== 8'hC0) begin
            bad++; $display("FAIL midrst_first: anode=%b cathode=%h want 1110 c0", anode, cathode);
        end
        for (int i = 0; i < 2 * ND * RD; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) n_busy++;
            total++;
            if (anode !== exp_anode(cyc) || cathode !== exp_cath(cyc)) begin
                bad++; $display("FAIL midrst_scan cyc=%0d: anode=%b cathode=%h want %b %h",
                                cyc, anode, cathode, exp_anode(cyc), exp_cath(cyc));
            end
        end
        total++;
        if (n_busy != 0 || overflow !== 1'b0) begin
            bad++; $display("FAIL midrst_pending: busy cycles=%0d overflow=%b want 0 0", n_busy, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_positive();
        test_negative_zero();
        test_overflow();
        test_back_to_back();
        test_blink();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
